// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter that time-shares the LED bank among NREQ status sources.
// Define LED_ARB_HEARTBEAT_EN to blink the whole bank from a free-running counter when idle.
module led_bank_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned HB_BITS     = 24,
    localparam int unsigned OWNER_W    = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   pattern,
    output logic [NREQ-1:0]         grant,
    output logic [OWNER_W-1:0]      owner,
    output logic                    busy,
    output logic [WIDTH-1:0]        led
);

    localparam int unsigned HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(HOLD_CYCLES - 1);

    if (NREQ < 2 || HOLD_CYCLES < 1 || HB_BITS < 1) begin : g_bad_param
        $error("led_bank_arbiter: illegal parameter value");
    end

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [OWNER_W-1:0]  last_q, last_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [WIDTH-1:0]    led_q, led_d;
    logic [WIDTH-1:0]    idle_led;
    logic                win_found;
    logic [OWNER_W-1:0]  win_idx;
    logic                rearb;
    logic [WIDTH-1:0]    pat [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pat
        assign pat[g] = pattern[g*WIDTH +: WIDTH];
    end

`ifdef LED_ARB_HEARTBEAT_EN
    logic [HB_BITS-1:0] hb_q, hb_d;

    assign hb_d = hb_q + HB_BITS'(1);
    // Use the incremented value so led tracks the counter MSB without an extra cycle of lag.
    assign idle_led = {WIDTH{hb_d[HB_BITS-1]}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hb_q <= '0;
        else          hb_q <= hb_d;
    end
`else
    assign idle_led = '0;
`endif

    // last always equals owner once a grant has been made, so one scan covers IDLE and HOLD.
    always_comb begin
        logic [OWNER_W-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = OWNER_W'((32'(last_q) + i) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= OWNER_W'(NREQ - 1);
            hcnt_q  <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hcnt_q  <= hcnt_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (win_found) state_d = StHold;
            StHold:  if (hcnt_q == '0 && !win_found) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        hcnt_d  = hcnt_q;
        led_d   = led_q;
        rearb   = 1'b0;
        unique case (state_q)
            StIdle: begin
                led_d = idle_led;
                rearb = 1'b1;
            end
            StHold: begin
                if (hcnt_q != '0) begin
                    hcnt_d = hcnt_q - HCNT_W'(1);
                    // A dropped request freezes the display but keeps the grant.
                    if (req[owner_q]) led_d = pat[owner_q];
                end else begin
                    rearb = 1'b1;
                end
            end
            default: ;
        endcase
        if (rearb) begin
            if (win_found) begin
                grant_d = NREQ'(1) << win_idx;
                owner_d = win_idx;
                last_d  = win_idx;
                hcnt_d  = HOLD_LOAD;
                led_d   = pat[win_idx];
            end else begin
                grant_d = '0;
                led_d   = idle_led;
            end
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = |grant_q;
    assign led   = led_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter: a cycle model queues expected outputs at each rising
// edge, they are compared on the falling edge, alongside directed scenario checks.
module tb_led_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 10;
    localparam int HOLD  = 4;
    localparam int HBB   = 4;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] pattern = '0;
    logic [NREQ-1:0]       grant;
    logic [1:0]            owner;
    logic                  busy;
    logic [WIDTH-1:0]      led;

    always #5 clk = ~clk;

    led_bank_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .HB_BITS(HBB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .pattern(pattern),
        .grant(grant), .owner(owner), .busy(busy), .led(led)
    );

    typedef struct packed {
        logic [NREQ-1:0]  grant;
        logic [1:0]       owner;
        logic             busy;
        logic [WIDTH-1:0] led;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model
    bit               m_hold;
    int               m_left, m_last, m_owner, m_base, m_w, m_c;
    logic [NREQ-1:0]  m_grant;
    logic [WIDTH-1:0] m_led, m_idle;
`ifdef LED_ARB_HEARTBEAT_EN
    logic [HBB-1:0]   m_hb;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hold = 0; m_left = 0; m_last = NREQ - 1; m_owner = 0;
            m_grant = '0; m_led = '0;
`ifdef LED_ARB_HEARTBEAT_EN
            m_hb = '0;
`endif
            exp_q.delete();
        end else begin
`ifdef LED_ARB_HEARTBEAT_EN
            m_hb = m_hb + 1'b1;
            m_idle = {WIDTH{m_hb[HBB-1]}};
`else
            m_idle = '0;
`endif
            if (!m_hold || m_left == 0) begin
                m_base = m_hold ? m_owner : m_last;
                m_w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    m_c = (m_base + k) % NREQ;
                    if (m_w < 0 && req[m_c]) m_w = m_c;
                end
                if (m_w >= 0) begin
                    m_hold = 1; m_owner = m_w; m_last = m_w; m_left = HOLD - 1;
                    m_grant = '0; m_grant[m_w] = 1'b1;
                    m_led = pattern[m_w*WIDTH +: WIDTH];
                end else begin
                    m_hold = 0; m_grant = '0; m_led = m_idle;
                end
            end else begin
                m_left--;
                if (req[m_owner]) m_led = pattern[m_owner*WIDTH +: WIDTH];
            end
            exp_q.push_back('{grant: m_grant, owner: 2'(m_owner), busy: |m_grant, led: m_led});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            check_eq("rst_grant", 32'(grant), 0);
            check_eq("rst_busy", 32'(busy), 0);
            check_eq("rst_led", 32'(led), 0);
            check_eq("rst_owner", 32'(owner), 0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("sb_grant", 32'(grant), 32'(e.grant));
            check_eq("sb_owner", 32'(owner), 32'(e.owner));
            check_eq("sb_busy", 32'(busy), 32'(e.busy));
            check_eq("sb_led", 32'(led), 32'(e.led));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] e_idle;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        // Idle display with no requests
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
`ifdef LED_ARB_HEARTBEAT_EN
            e_idle = (((i + 1) / 8) % 2) != 0 ? 10'h3FF : 10'h000;
`else
            e_idle = 10'h000;
`endif
            check_eq("idle_led", 32'(led), 32'(e_idle));
            check_eq("idle_grant", 32'(grant), 0);
            check_eq("idle_busy", 32'(busy), 0);
        end

        // Single requester: live pattern, freeze on drop, release after HOLD cycles
        pattern[9:0] = 10'h155; req = 4'b0001;
        @(negedge clk);
        check_eq("t2_grant", 32'(grant), 32'h1);
        check_eq("t2_owner", 32'(owner), 0);
        check_eq("t2_busy", 32'(busy), 1);
        check_eq("t2_led", 32'(led), 32'h155);
        pattern[9:0] = 10'h2AA;
        @(negedge clk);
        check_eq("t2_live", 32'(led), 32'h2AA);
        req = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            check_eq("t2_hold", 32'(grant), 32'h1);
            check_eq("t2_frozen", 32'(led), 32'h2AA);
        end
        @(negedge clk);
        check_eq("t2_release", 32'(grant), 0);
        check_eq("t2_rel_busy", 32'(busy), 0);

        // All requesting from reset: strict rotation, no gaps
        @(negedge clk);
        #1 reset_n = 1'b0;
        req = 4'hF;
        pattern = {10'h300, 10'h0C0, 10'h030, 10'h00C};
        @(negedge clk);
        #1 reset_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < HOLD; c++) begin
                @(negedge clk);
                check_eq("t3_grant", 32'(grant), 32'(1) << (g % NREQ));
                check_eq("t3_busy", 32'(busy), 1);
            end
        end

        // Asynchronous reset mid-hold
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5_async_grant", 32'(grant), 0);
        check_eq("t5_async_busy", 32'(busy), 0);
        check_eq("t5_async_led", 32'(led), 0);
        check_eq("t5_async_owner", 32'(owner), 0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_eq("t5_first", 32'(grant), 32'h1);
        req = 4'b0000;
        repeat (6) @(negedge clk);

        // Requester 1 drops early: grant held with frozen display, then requester 2
        pattern[19:10] = 10'h0F0; pattern[29:20] = 10'h00F; req = 4'b0110;
        @(negedge clk);
        check_eq("t4_grant", 32'(grant), 32'h2);
        check_eq("t4_led", 32'(led), 32'h0F0);
        req = 4'b0100;
        repeat (3) begin
            @(negedge clk);
            check_eq("t4_hold", 32'(grant), 32'h2);
            check_eq("t4_frozen", 32'(led), 32'h0F0);
        end
        @(negedge clk);
        check_eq("t4_next", 32'(grant), 32'h4);
        check_eq("t4_next_led", 32'(led), 32'h00F);

        // Random traffic checked by the scoreboard
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
            pattern = 40'({$urandom(), $urandom()});
        end
        req = 4'b0000;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
